// File: rtl/uart_tx_engine.sv
// UART transmit serialiser: start bit, 5-8 data bits LSB first, optional parity,
// 1 or 2 stop bits, with an internal baud tick generator chosen from four divisors.
module uart_tx_engine #(
    parameter int MAX_UART_DATA_W = 8,
    parameter int STOP_CONF_W     = 2,
    parameter int DATA_CONF_W     = 2,
    parameter int TOTAL_CONF_W    = STOP_CONF_W + DATA_CONF_W + 1,
    parameter int BAUD_RATE_SEL_W = 2,
    parameter int BAUD_DIV_0      = 10417,
    parameter int BAUD_DIV_1      = 5208,
    parameter int BAUD_DIV_2      = 868,
    parameter int BAUD_DIV_3      = 109,
    parameter int BAUD_CNT_W      = 16,
    parameter int PARITY_ODD      = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       tx_en_i,
    input  logic                       tx_start_i,
    input  logic [TOTAL_CONF_W-1:0]    tx_conf_i,
    input  logic [MAX_UART_DATA_W-1:0] tx_data_i,
    input  logic [BAUD_RATE_SEL_W-1:0] baud_sel_i,
    output logic                       tx_o,
    output logic                       tx_busy_o,
    output logic                       tx_done_o
);

    localparam int   IDX_W    = (MAX_UART_DATA_W > 1) ? $clog2(MAX_UART_DATA_W) : 1;
    localparam logic PAR_INIT = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                     r_state;
    logic                       r_start_q;
    logic [BAUD_CNT_W-1:0]      r_baud_cnt;
    logic [BAUD_CNT_W-1:0]      r_div_m1;
    logic [MAX_UART_DATA_W-1:0] r_shift;
    logic [IDX_W-1:0]           r_last_idx;
    logic [IDX_W-1:0]           r_bit_idx;
    logic                       r_par_en;
    logic                       r_two_stop;
    logic                       r_parity;
    logic                       r_stop_cnt;
    logic                       r_tx;
    logic                       r_busy;
    logic                       r_done;

    state_t                     w_state_next;
    logic [BAUD_CNT_W-1:0]      w_baud_next;
    logic [BAUD_CNT_W-1:0]      w_div_m1_next;
    logic [MAX_UART_DATA_W-1:0] w_shift_next;
    logic [IDX_W-1:0]           w_last_idx_next;
    logic [IDX_W-1:0]           w_bit_idx_next;
    logic                       w_par_en_next;
    logic                       w_two_stop_next;
    logic                       w_parity_next;
    logic                       w_stop_cnt_next;
    logic                       w_tx_next;
    logic                       w_busy_next;
    logic                       w_done_next;

    logic [BAUD_CNT_W-1:0]      w_div;
    logic [IDX_W-1:0]           w_conf_last_idx;
    logic                       w_conf_two_stop;
    logic                       w_conf_par_en;
    logic                       w_start_edge;
    logic                       w_tick;

    // Divisor and frame format decoded from the live inputs; only sampled at frame start.
    always_comb begin
        if (baud_sel_i == BAUD_RATE_SEL_W'(0)) begin
            w_div = BAUD_CNT_W'(BAUD_DIV_0);
        end else if (baud_sel_i == BAUD_RATE_SEL_W'(1)) begin
            w_div = BAUD_CNT_W'(BAUD_DIV_1);
        end else if (baud_sel_i == BAUD_RATE_SEL_W'(2)) begin
            w_div = BAUD_CNT_W'(BAUD_DIV_2);
        end else begin
            w_div = BAUD_CNT_W'(BAUD_DIV_3);
        end
    end

    assign w_conf_last_idx = IDX_W'(4) + IDX_W'(tx_conf_i[TOTAL_CONF_W-1 -: DATA_CONF_W]);
    assign w_conf_two_stop = |tx_conf_i[STOP_CONF_W:1];
    assign w_conf_par_en   = tx_conf_i[0];
    assign w_start_edge    = tx_start_i & ~r_start_q;
    assign w_tick          = (r_baud_cnt == '0);

    always_comb begin
        w_state_next    = r_state;
        w_baud_next     = r_baud_cnt;
        w_div_m1_next   = r_div_m1;
        w_shift_next    = r_shift;
        w_last_idx_next = r_last_idx;
        w_bit_idx_next  = r_bit_idx;
        w_par_en_next   = r_par_en;
        w_two_stop_next = r_two_stop;
        w_parity_next   = r_parity;
        w_stop_cnt_next = r_stop_cnt;
        w_tx_next       = r_tx;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;

        if (r_state != S_IDLE) begin
            w_baud_next = w_tick ? r_div_m1 : (r_baud_cnt - BAUD_CNT_W'(1));
        end

        // Losing enable mid-frame drops the frame outright; no done pulse follows.
        if (r_state != S_IDLE && !tx_en_i) begin
            w_state_next = S_IDLE;
            w_baud_next  = '0;
            w_tx_next    = 1'b1;
            w_busy_next  = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (tx_en_i && w_start_edge) begin
                        w_state_next    = S_START;
                        w_div_m1_next   = w_div - BAUD_CNT_W'(1);
                        w_baud_next     = w_div - BAUD_CNT_W'(1);
                        w_shift_next    = tx_data_i;
                        w_last_idx_next = w_conf_last_idx;
                        w_par_en_next   = w_conf_par_en;
                        w_two_stop_next = w_conf_two_stop;
                        w_tx_next       = 1'b0;
                        w_busy_next     = 1'b1;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        w_state_next   = S_DATA;
                        w_tx_next      = r_shift[0];
                        w_shift_next   = r_shift >> 1;
                        w_parity_next  = r_shift[0];
                        w_bit_idx_next = '0;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == r_last_idx) begin
                            if (r_par_en) begin
                                w_state_next = S_PARITY;
                                w_tx_next    = r_parity ^ PAR_INIT;
                            end else begin
                                w_state_next    = S_STOP;
                                w_tx_next       = 1'b1;
                                w_stop_cnt_next = r_two_stop;
                            end
                        end else begin
                            w_tx_next      = r_shift[0];
                            w_shift_next   = r_shift >> 1;
                            w_parity_next  = r_parity ^ r_shift[0];
                            w_bit_idx_next = r_bit_idx + IDX_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        w_state_next    = S_STOP;
                        w_tx_next       = 1'b1;
                        w_stop_cnt_next = r_two_stop;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_stop_cnt) begin
                            w_stop_cnt_next = 1'b0;
                        end else begin
                            w_state_next = S_IDLE;
                            w_baud_next  = '0;
                            w_busy_next  = 1'b0;
                            w_done_next  = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_baud_next  = '0;
                    w_tx_next    = 1'b1;
                    w_busy_next  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_start_q  <= 1'b0;
            r_baud_cnt <= '0;
            r_div_m1   <= '0;
            r_shift    <= '0;
            r_last_idx <= '0;
            r_bit_idx  <= '0;
            r_par_en   <= 1'b0;
            r_two_stop <= 1'b0;
            r_parity   <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_start_q  <= tx_start_i;
            r_baud_cnt <= w_baud_next;
            r_div_m1   <= w_div_m1_next;
            r_shift    <= w_shift_next;
            r_last_idx <= w_last_idx_next;
            r_bit_idx  <= w_bit_idx_next;
            r_par_en   <= w_par_en_next;
            r_two_stop <= w_two_stop_next;
            r_parity   <= w_parity_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    assign tx_o      = r_tx;
    assign tx_busy_o = r_busy;
    assign tx_done_o = r_done;

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- UART transmit serialiser. Sits directly downstream of the UART register controller.
- Consumes the controller's tx_en, tx_start, tx_conf, tx_data and baud_sel outputs.
- Drives the serial TX line and returns tx_busy and tx_done status to the controller.
- Contains its own baud-rate tick generator, selected from four compile-time clock-divisor constants.

Parameters:
- MAX_UART_DATA_W, 8: width of tx_data_i; max data bits per frame.
- STOP_CONF_W, 2: width of stop-bit config field.
- DATA_CONF_W, 2: width of data-bit config field.
- TOTAL_CONF_W, STOP_CONF_W+DATA_CONF_W+1: width of tx_conf_i.
- BAUD_RATE_SEL_W, 2: width of baud_sel_i.
- BAUD_DIV_0, 10417: clock cycles per bit for baud_sel 0 (9600 @ 100 MHz).
- BAUD_DIV_1, 5208: clock cycles per bit for baud_sel 1 (19200 @ 100 MHz).
- BAUD_DIV_2, 868: clock cycles per bit for baud_sel 2 (115200 @ 100 MHz).
- BAUD_DIV_3, 109: clock cycles per bit for baud_sel 3 (921600 @ 100 MHz).
- BAUD_CNT_W, 16: baud counter width. Every BAUD_DIV_x must be >= 2 and < 2**BAUD_CNT_W.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity.

Ports:
- clk_i  in  1  top clock.
- rst_ni  in  1  asynchronous active-low reset.
- tx_en_i  in  1  transmitter enable.
- tx_start_i  in  1  start request; level from control register, acted on at its rising edge.
- tx_conf_i  in  TOTAL_CONF_W  {data[1:0], stop[1:0], parity_en}.
- tx_data_i  in  MAX_UART_DATA_W  character to send, LSB first.
- baud_sel_i  in  BAUD_RATE_SEL_W  selects BAUD_DIV_0..3.
- tx_o  out  1  serial line, idle high.
- tx_busy_o  out  1  high while a frame is in progress.
- tx_done_o  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst_ni low, async): tx_o=1, tx_busy_o=0, tx_done_o=0, state=IDLE, all counters 0, start edge register=0. All outputs are registered.
- Config decode:
  - conf[4:3] data bits: 00=5, 01=6, 10=7, 11=8.
  - conf[2:1] stop bits: 00=1, 01/10/11=2.
  - conf[0]: parity enable.
- Start edge: start_q <= tx_start_i every cycle. Edge = tx_start_i & ~start_q. A level held high never retriggers; it must go low, then high.
- IDLE -> START when tx_en_i=1 and edge in the same cycle.
  - On that edge: tx_data_i, decoded conf and divisor (from baud_sel_i) are latched.
  - Also on that edge: tx_o<=0, tx_busy_o<=1, baud counter <= DIV-1.
  - Edges in non-IDLE states, or with tx_en_i=0, are ignored (not queued).
- Baud counter decrements each cycle. Tick = counter==0, which reloads it to DIV-1. Each bit therefore lasts exactly DIV cycles.
- On each tick the FSM advances:
  - START -> DATA: sends bit0.
  - DATA: shift LSB first. After N data bits -> PARITY if enabled, else STOP.
  - PARITY: sends XOR of the N sent bits, XOR PARITY_ODD.
  - STOP: tx_o=1 for 1 or 2 bit periods.
- End of final stop bit tick: -> IDLE, tx_busy_o<=0, tx_done_o<=1 for exactly one cycle.
- Frame length = DIV*(1+N+P+S) cycles, measured from tx_o falling to the tx_done_o cycle.
- Bits above the configured width in tx_data_i are ignored, and excluded from parity.
- Mid-frame changes of tx_data_i, tx_conf_i or baud_sel_i have no effect until the next frame.
- tx_en_i=0 mid-frame: abort at the next clock edge. tx_o<=1, tx_busy_o<=0, no tx_done_o, state=IDLE.
- Back-to-back frames: a new edge is accepted in the cycle tx_done_o is high, since the FSM is already IDLE. The controller clears start one cycle later, so software produces a new edge.
- Reset asserted mid-frame: line returns high immediately (async), no done pulse.

Test Plan:
- 8N1 frame: BAUD_DIV_0=4, baud_sel=0, conf=5'b11_00_0, data=8'hA5, start 0->1.
  - tx_o = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; busy high 40 cycles.
  - tx_done_o one-cycle pulse on cycle 41, coincident with busy falling.
- 7E2 frame: conf=5'b10_01_1, data=8'hD3.
  - Data bits 1,1,0,0,1,0,1 (bit7 ignored), parity 0, two stop bits.
  - 11 bit periods total; repeat with PARITY_ODD=1, parity bit=1.
- 5-bit with parity: conf=5'b00_00_1, data=8'hFF, baud_sel=3 with BAUD_DIV_3=2.
  - Bits 1,1,1,1,1, parity 1; each bit 2 cycles.
- Retrigger and ignore rules:
  - Hold tx_start_i high past tx_done -> no second frame.
  - Drop then raise start -> second frame begins.
  - Start edge with tx_en_i=0 -> tx_o stays 1, busy stays 0.
- Abort and reset:
  - Deassert tx_en_i during data bit 3 -> tx_o=1 and busy=0 next cycle, tx_done never pulses.
  - Assert rst_ni low mid-frame -> tx_o=1 asynchronously.
- Latching: change data, conf and baud_sel during DATA -> current frame bits and timing unchanged; next frame uses the new values.
